// File: rtl/rv_alu.sv
// -----------------------------------------------------------------------------
// rv_alu : RV64I integer ALU for the execute stage.
//
// Evaluates one operation per cycle on the operands selected by execute and
// registers the result, so alu_out / compare_out reflect the operands and
// opcode present at the previous rising clock edge.
//
// Ports
//   clk          in   1          clock, rising edge
//   rst_n        in   1          asynchronous active-low reset
//   alu_a_i      in   XLEN       operand A (rs1 / pc / 0)
//   alu_b_i      in   XLEN       operand B (rs2 / imm / 4)
//   alu_op_i     in   ALUOP_LEN  operation select
//   alu_out      out  XLEN       registered result
//   compare_out  out  1          registered compare / branch-taken flag
// -----------------------------------------------------------------------------
module rv_alu #(
    parameter int XLEN      = 64,
    parameter int ALUOP_LEN = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      alu_a_i,
    input  logic [XLEN-1:0]      alu_b_i,
    input  logic [ALUOP_LEN-1:0] alu_op_i,
    output logic [XLEN-1:0]      alu_out,
    output logic                 compare_out
);

    // Opcode map
    localparam logic [ALUOP_LEN-1:0] OP_NOP  = 5'd0;
    localparam logic [ALUOP_LEN-1:0] OP_ADD  = 5'd1;
    localparam logic [ALUOP_LEN-1:0] OP_SUB  = 5'd2;
    localparam logic [ALUOP_LEN-1:0] OP_SLL  = 5'd3;
    localparam logic [ALUOP_LEN-1:0] OP_SLT  = 5'd4;
    localparam logic [ALUOP_LEN-1:0] OP_SLTU = 5'd5;
    localparam logic [ALUOP_LEN-1:0] OP_XOR  = 5'd6;
    localparam logic [ALUOP_LEN-1:0] OP_SRL  = 5'd7;
    localparam logic [ALUOP_LEN-1:0] OP_SRA  = 5'd8;
    localparam logic [ALUOP_LEN-1:0] OP_OR   = 5'd9;
    localparam logic [ALUOP_LEN-1:0] OP_AND  = 5'd10;
    localparam logic [ALUOP_LEN-1:0] OP_ADDW = 5'd11;
    localparam logic [ALUOP_LEN-1:0] OP_SUBW = 5'd12;
    localparam logic [ALUOP_LEN-1:0] OP_SLLW = 5'd13;
    localparam logic [ALUOP_LEN-1:0] OP_SRLW = 5'd14;
    localparam logic [ALUOP_LEN-1:0] OP_SRAW = 5'd15;
    localparam logic [ALUOP_LEN-1:0] OP_BEQ  = 5'd16;
    localparam logic [ALUOP_LEN-1:0] OP_BNE  = 5'd17;
    localparam logic [ALUOP_LEN-1:0] OP_BLT  = 5'd18;
    localparam logic [ALUOP_LEN-1:0] OP_BGE  = 5'd19;
    localparam logic [ALUOP_LEN-1:0] OP_BLTU = 5'd20;
    localparam logic [ALUOP_LEN-1:0] OP_BGEU = 5'd21;

    // Sign-extend a 32-bit W-op result to the full register width.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = {{(XLEN-32){v[31]}}, v};
    endfunction

    // Place a single-bit compare outcome in bit 0 of a result word.
    function automatic logic [XLEN-1:0] flag_word(input logic f);
        flag_word = {{(XLEN-1){1'b0}}, f};
    endfunction

    // Only the low 6 bits (64-bit ops) or 5 bits (W-ops) select the shift.
    logic [5:0]      w_shamt;
    logic [4:0]      w_shamt_w;
    logic [31:0]     w_a32;
    logic [31:0]     w_b32;

    logic [XLEN-1:0] w_add;
    logic [XLEN-1:0] w_sub;
    logic [XLEN-1:0] w_sll;
    logic [XLEN-1:0] w_srl;
    logic [XLEN-1:0] w_sra;
    logic [31:0]     w_addw;
    logic [31:0]     w_subw;
    logic [31:0]     w_sllw;
    logic [31:0]     w_srlw;
    logic [31:0]     w_sraw;

    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;

    logic [XLEN-1:0] w_next_res;
    logic            w_next_cmp;

    logic [XLEN-1:0] r_alu_out;
    logic            r_compare_out;

    assign w_shamt   = alu_b_i[5:0];
    assign w_shamt_w = alu_b_i[4:0];
    assign w_a32     = alu_a_i[31:0];
    assign w_b32     = alu_b_i[31:0];

    // Arithmetic wraps silently; no overflow indication is produced.
    assign w_add  = alu_a_i + alu_b_i;
    assign w_sub  = alu_a_i - alu_b_i;
    assign w_sll  = alu_a_i << w_shamt;
    assign w_srl  = alu_a_i >> w_shamt;
    assign w_sra  = $unsigned($signed(alu_a_i) >>> w_shamt);

    assign w_addw = w_a32 + w_b32;
    assign w_subw = w_a32 - w_b32;
    assign w_sllw = w_a32 << w_shamt_w;
    assign w_srlw = w_a32 >> w_shamt_w;
    // SRAW replicates bit 31 of the 32-bit source, not bit 63 of the operand.
    assign w_sraw = $unsigned($signed(w_a32) >>> w_shamt_w);

    assign w_eq   = (alu_a_i == alu_b_i);
    assign w_lt_s = ($signed(alu_a_i) < $signed(alu_b_i));
    assign w_lt_u = (alu_a_i < alu_b_i);

    // Next-result selection; NOP and reserved opcodes leave both zero.
    always_comb begin
        w_next_res = {XLEN{1'b0}};
        w_next_cmp = 1'b0;
        case (alu_op_i)
            OP_NOP:  w_next_res = {XLEN{1'b0}};
            OP_ADD:  w_next_res = w_add;
            OP_SUB:  w_next_res = w_sub;
            OP_SLL:  w_next_res = w_sll;
            OP_SLT: begin
                w_next_cmp = w_lt_s;
                w_next_res = flag_word(w_lt_s);
            end
            OP_SLTU: begin
                w_next_cmp = w_lt_u;
                w_next_res = flag_word(w_lt_u);
            end
            OP_XOR:  w_next_res = alu_a_i ^ alu_b_i;
            OP_SRL:  w_next_res = w_srl;
            OP_SRA:  w_next_res = w_sra;
            OP_OR:   w_next_res = alu_a_i | alu_b_i;
            OP_AND:  w_next_res = alu_a_i & alu_b_i;
            OP_ADDW: w_next_res = sext32(w_addw);
            OP_SUBW: w_next_res = sext32(w_subw);
            OP_SLLW: w_next_res = sext32(w_sllw);
            OP_SRLW: w_next_res = sext32(w_srlw);
            OP_SRAW: w_next_res = sext32(w_sraw);
            OP_BEQ: begin
                w_next_cmp = w_eq;
                w_next_res = flag_word(w_eq);
            end
            OP_BNE: begin
                w_next_cmp = ~w_eq;
                w_next_res = flag_word(~w_eq);
            end
            OP_BLT: begin
                w_next_cmp = w_lt_s;
                w_next_res = flag_word(w_lt_s);
            end
            OP_BGE: begin
                w_next_cmp = ~w_lt_s;
                w_next_res = flag_word(~w_lt_s);
            end
            OP_BLTU: begin
                w_next_cmp = w_lt_u;
                w_next_res = flag_word(w_lt_u);
            end
            OP_BGEU: begin
                w_next_cmp = ~w_lt_u;
                w_next_res = flag_word(~w_lt_u);
            end
            default: begin
                w_next_res = {XLEN{1'b0}};
                w_next_cmp = 1'b0;
            end
        endcase
    end

    // Output register; reset drops any result that was about to be captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out     <= {XLEN{1'b0}};
            r_compare_out <= 1'b0;
        end else begin
            r_alu_out     <= w_next_res;
            r_compare_out <= w_next_cmp;
        end
    end

    assign alu_out     = r_alu_out;
    assign compare_out = r_compare_out;

endmodule

// File: tb/tb_rv_alu.sv
// -----------------------------------------------------------------------------
// tb_rv_alu : self-checking bench for rv_alu.
//
// A behavioural model computes the expected result from the operands present
// at each rising edge; a compare process checks both outputs at the following
// falling edge. Directed vectors with hand-computed answers pin the model and
// the DUT, and randomized operands/opcodes cover the rest.
// -----------------------------------------------------------------------------
module tb_rv_alu;

    logic        clk;
    logic        rst_n;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [4:0]  alu_op;
    logic [63:0] alu_out;
    logic        compare_out;

    int          n_checks;
    int          n_errors;
    bit          chk_en;

    rv_alu #(
        .XLEN      (64),
        .ALUOP_LEN (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_a_i     (alu_a),
        .alu_b_i     (alu_b),
        .alu_op_i    (alu_op),
        .alu_out     (alu_out),
        .compare_out (compare_out)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model computed straight from the opcode definitions.
    function automatic void model(input  logic [63:0] a,
                                  input  logic [63:0] b,
                                  input  logic [4:0]  op,
                                  output logic [63:0] r,
                                  output logic        c);
        longint signed sa;
        longint signed sb;
        int signed     w;
        logic [31:0]   a_lo;
        logic [31:0]   b_lo;
        sa   = a;
        sb   = b;
        a_lo = a[31:0];
        b_lo = b[31:0];
        w    = 32'sd0;
        r    = 64'd0;
        c    = 1'b0;
        case (op)
            5'd1:  r = a + b;
            5'd2:  r = a - b;
            5'd3:  r = a << b[5:0];
            5'd4:  c = (sa < sb);
            5'd5:  c = (a < b);
            5'd6:  r = a ^ b;
            5'd7:  r = a >> b[5:0];
            5'd8:  r = sa >>> b[5:0];
            5'd9:  r = a | b;
            5'd10: r = a & b;
            5'd11: begin w = a_lo + b_lo;        r = longint'(w); end
            5'd12: begin w = a_lo - b_lo;        r = longint'(w); end
            5'd13: begin w = a_lo << b[4:0];     r = longint'(w); end
            5'd14: begin w = a_lo >> b[4:0];     r = longint'(w); end
            5'd15: begin w = int'(a_lo) >>> b[4:0]; r = longint'(w); end
            5'd16: c = (a == b);
            5'd17: c = (a != b);
            5'd18: c = (sa < sb);
            5'd19: c = (sa >= sb);
            5'd20: c = (a < b);
            5'd21: c = (a >= b);
            default: r = 64'd0;
        endcase
        if ((op == 5'd4) || (op == 5'd5) || ((op >= 5'd16) && (op <= 5'd21)))
            r = 64'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: expectation from the inputs at each rising edge,
    // checked against the DUT at the next falling edge.
    logic [63:0] exp_res;
    logic        exp_cmp;
    initial begin
        exp_res = 64'd0;
        exp_cmp = 1'b0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                model(alu_a, alu_b, alu_op, exp_res, exp_cmp);
            end else begin
                exp_res = 64'd0;
                exp_cmp = 1'b0;
            end
            @(negedge clk);
            if (!rst_n) begin
                exp_res = 64'd0;
                exp_cmp = 1'b0;
            end
            if (chk_en) begin
                chk("cycle_res", alu_out, exp_res);
                chk("cycle_cmp", 64'(compare_out), 64'(exp_cmp));
            end
        end
    end

    // Directed vector: pin the model to a literal, then the DUT one cycle on.
    // Entered and left at posedge+1.
    task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] op, input logic [63:0] er, input logic ec);
        logic [63:0] mr;
        logic        mc;
        model(a, b, op, mr, mc);
        chk({name, "_model_res"}, mr, er);
        chk({name, "_model_cmp"}, 64'(mc), 64'(ec));
        alu_a  = a;
        alu_b  = b;
        alu_op = op;
        @(posedge clk);
        #1;
        chk({name, "_res"}, alu_out, er);
        chk({name, "_cmp"}, 64'(compare_out), 64'(ec));
    endtask

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h8000_0000_0000_0000;
            3:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            4:       v = 64'(32'h8000_0000);
            5:       v = 64'($urandom_range(0, 70));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b1;
        alu_a    = 64'hDEAD_BEEF_0123_4567;
        alu_b    = 64'h0000_0000_0000_0001;
        alu_op   = 5'd1;

        // Reset acts without any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("reset_res", alu_out, 64'd0);
        chk("reset_cmp", 64'(compare_out), 64'd0);
        chk_en = 1'b1;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-computed vectors.
        directed("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd1, 64'd0, 1'b0);
        directed("sub_wrap", 64'd0, 64'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        directed("addw_sext", 64'h0000_0000_7FFF_FFFF, 64'd1, 5'd11, 64'hFFFF_FFFF_8000_0000, 1'b0);
        directed("sraw", 64'h0000_0000_8000_0000, 64'd4, 5'd15, 64'hFFFF_FFFF_F800_0000, 1'b0);
        directed("sll_b41", 64'd1, 64'h41, 5'd3, 64'd2, 1'b0);
        directed("sll_hi_ignored", 64'h1234, 64'hFFFF_FFFF_FFFF_FFC0, 5'd3, 64'h1234, 1'b0);
        directed("sra63", 64'h8000_0000_0000_0000, 64'd63, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        directed("sllw_zero", 64'h0000_0000_8000_0000, 64'd0, 5'd13, 64'hFFFF_FFFF_8000_0000, 1'b0);
        directed("srlw31", 64'hFFFF_FFFF_8000_0000, 64'd31, 5'd14, 64'd1, 1'b0);
        directed("slt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd4, 64'd1, 1'b1);
        directed("sltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5, 64'd0, 1'b0);
        directed("blt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd18, 64'd1, 1'b1);
        directed("bge", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd19, 64'd0, 1'b0);
        directed("bgeu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd21, 64'd1, 1'b1);
        directed("beq", 64'd5, 64'd5, 5'd16, 64'd1, 1'b1);
        directed("bne", 64'd5, 64'd5, 5'd17, 64'd0, 1'b0);
        directed("reserved25", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd25, 64'd0, 1'b0);
        directed("xor", 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_0000_1234, 5'd6, 64'hFF00_FFFF_FFFF_0000, 1'b0);

        // Alternating ADD/XOR; the compare process checks each 1-cycle result.
        for (int i = 0; i < 24; i++) begin
            alu_a  = pick_operand();
            alu_b  = pick_operand();
            alu_op = (i % 2 == 0) ? 5'd1 : 5'd6;
            @(posedge clk);
            #1;
        end

        // Reset in the middle of an operation discards the pending result.
        alu_a  = 64'd100;
        alu_b  = 64'd23;
        alu_op = 5'd1;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_res", alu_out, 64'd0);
        chk("midreset_cmp", 64'(compare_out), 64'd0);
        @(posedge clk);
        #1;
        chk("midreset_held", alu_out, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("after_reset_add", alu_out, 64'd123);

        // Randomized operands and opcodes over the whole opcode space.
        for (int i = 0; i < 3000; i++) begin
            alu_a  = pick_operand();
            alu_b  = pick_operand();
            alu_op = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
